// File: rtl/tcdm_strided_reader_if.sv
// TCDM read port plus the in-order response stream of the strided reader.
// The master side is the reader; the slave side is memory plus stream sink.
interface tcdm_strided_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    tcdm_req;
    logic                    tcdm_gnt;
    logic [ADDR_WIDTH-1:0]   tcdm_add;
    logic                    tcdm_wen;
    logic [DATA_WIDTH/8-1:0] tcdm_be;
    logic [DATA_WIDTH-1:0]   tcdm_data;
    logic [DATA_WIDTH-1:0]   tcdm_r_data;
    logic                    tcdm_r_valid;
    logic [DATA_WIDTH-1:0]   data;
    logic                    valid;
    logic                    ready;

    modport master (
        output tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data, data, valid,
        input  tcdm_gnt, tcdm_r_data, tcdm_r_valid, ready
    );

    modport slave (
        input  tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data, data, valid,
        output tcdm_gnt, tcdm_r_data, tcdm_r_valid, ready
    );
endinterface

// File: rtl/tcdm_strided_reader.sv
// Strided TCDM read master: one (base, stride, length) job becomes word reads,
// responses are buffered in a credit-limited FIFO and streamed out in order.
module tcdm_strided_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH-1:0] stride_i,
    input  logic [LEN_WIDTH-1:0]  length_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    tcdm_strided_reader_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q, stride_q;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic [CW-1:0]         outst_q, outst_d, cnt_q, cnt_d;
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  err_q, done_q, ign_q;
    logic                  req, gnt, rsp, push, pop;
    logic [CW:0]           used;

    // Credit counts in-flight reads plus buffered words, so a push never finds the FIFO full.
    assign used    = {1'b0, outst_q} + {1'b0, cnt_q};
    assign req     = (state_q == ISSUE) && (used < DEPTH_C);
    assign gnt     = req & bus.tcdm_gnt;
    // Responses are ignored between reset and the first start: they belong to an aborted job.
    assign rsp     = bus.tcdm_r_valid & ~ign_q;
    assign push    = rsp && (outst_q != '0);
    assign pop     = (cnt_q != '0) && bus.ready;
    assign outst_d = outst_q + CW'(gnt) - CW'(push);
    assign cnt_d   = cnt_q + CW'(push) - CW'(pop);

    assign bus.tcdm_req  = req;
    assign bus.tcdm_add  = addr_q;
    assign bus.tcdm_wen  = 1'b1;
    assign bus.tcdm_be   = '1;
    assign bus.tcdm_data = '0;
    assign bus.data      = mem_q[rptr_q];
    assign bus.valid     = (cnt_q != '0);
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
    assign err_o         = err_q;

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= bus.tcdm_r_data;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            stride_q <= '0;
            rem_q    <= '0;
            outst_q  <= '0;
            cnt_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            ign_q    <= 1'b1;
        end else begin
            outst_q <= outst_d;
            cnt_q   <= cnt_d;
            done_q  <= (state_q == DONE);
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            if (rsp && (outst_q == '0)) err_q <= 1'b1;
            if (gnt) begin
                addr_q <= addr_q + stride_q;
                rem_q  <= rem_q - 1'b1;
            end
            case (state_q)
                IDLE: if (start_i) begin
                    addr_q   <= base_addr_i;
                    stride_q <= stride_i;
                    rem_q    <= length_i;
                    err_q    <= 1'b0;
                    ign_q    <= 1'b0;
                    state_q  <= (length_i == '0) ? DONE : ISSUE;
                end
                ISSUE: if (gnt && (rem_q == LEN_WIDTH'(1))) state_q <= DRAIN;
                DRAIN: if ((outst_d == '0) && (cnt_d == '0)) state_q <= DONE;
                DONE:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
